// File: rtl/cci_mpf_prim_repl_plru.sv
// Victim selection for set-associative MPF caches: tree pseudo-LRU per set, or LFSR random.
// The port list matches the other replacement primitives, so callers can swap policies freely.
module cci_mpf_prim_repl_plru #(
    parameter int N_WAYS    = 4,
    parameter int N_ENTRIES = 1024,
    parameter int MODE      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         rdy,
    input  logic [$clog2(N_ENTRIES)-1:0] lookupIdx,
    input  logic                         lookupEn,
    output logic [N_WAYS-1:0]            lookupVecRsp,
    output logic [$clog2(N_WAYS)-1:0]    lookupRsp,
    output logic                         lookupRspRdy,
    input  logic [$clog2(N_ENTRIES)-1:0] refIdx0,
    input  logic [N_WAYS-1:0]            refWayVec0,
    input  logic                         refEn0,
    input  logic [$clog2(N_ENTRIES)-1:0] refIdx1,
    input  logic [N_WAYS-1:0]            refWayVec1,
    input  logic                         refEn1
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int WAY_W = $clog2(N_WAYS);
    localparam int NODES = N_WAYS - 1;
    localparam logic [NODES-1:0] NODE_ONE = NODES'(1'b1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    if ((N_WAYS < 2) || ((N_WAYS & (N_WAYS - 1)) != 0)) begin : g_bad_ways
        $error("cci_mpf_prim_repl_plru: N_WAYS must be a power of 2 and >= 2");
    end
    if ((N_ENTRIES < 2) || ((N_ENTRIES & (N_ENTRIES - 1)) != 0)) begin : g_bad_entries
        $error("cci_mpf_prim_repl_plru: N_ENTRIES must be a power of 2 and >= 2");
    end
    if ((MODE != 0) && (MODE != 1)) begin : g_bad_mode
        $error("cci_mpf_prim_repl_plru: MODE must be 0 or 1");
    end

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Lowest set bit of a way vector (caller qualifies the all-zero case).
    function automatic logic [WAY_W-1:0] lowest_way(input logic [N_WAYS-1:0] vec);
        logic [WAY_W-1:0]  way;
        logic [N_WAYS-1:0] sh;
        way = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            sh  = vec >> i;
            way = sh[0] ? WAY_W'(i) : way;
        end
        return way;
    endfunction

    // Point every node on the path to 'way' at the opposite subtree.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                    input logic [WAY_W-1:0] way);
        logic [NODES-1:0] t;
        logic [WAY_W-1:0] w;
        int               n;
        t = tree;
        w = way;
        n = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            if (w[WAY_W-1]) begin
                t = t & ~(NODE_ONE << n);
                n = 2 * n + 2;
            end else begin
                t = t | (NODE_ONE << n);
                n = 2 * n + 1;
            end
            w = w << 1'b1;
        end
        return t;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] tree);
        logic [WAY_W-1:0] way;
        logic [NODES-1:0] sh;
        int               n;
        way = '0;
        n   = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh  = tree >> n;
            way = (way << 1'b1) | WAY_W'(sh[0]);
            n   = sh[0] ? (2 * n + 2) : (2 * n + 1);
        end
        return way;
    endfunction

    function automatic logic [11:0] lfsr_step(input logic [11:0] s);
        return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
    endfunction

    state_t             state_q;
    logic [IDX_W-1:0]   init_cnt_q;
    logic               rdy_q;
    logic               rsp_rdy_q;
    logic [WAY_W-1:0]   rsp_q;
    logic [N_WAYS-1:0]  vec_q;
    logic [11:0]        lfsr_q;
    logic [11:0]        lfsr_d;
    logic               accept_s;
    logic               init_we_s;
    logic [WAY_W-1:0]   plru_victim_s;
    logic [WAY_W-1:0]   victim_s;

    assign accept_s  = lookupEn & rdy_q & ~reset;
    assign init_we_s = (state_q == ST_INIT) & ~reset;
    assign lfsr_d    = lfsr_step(lfsr_q);
    assign victim_s  = (MODE == 1) ? lfsr_q[WAY_W-1:0] : plru_victim_s;

    if (MODE == 0) begin : g_plru
        logic [NODES-1:0] tree_q [N_ENTRIES];
        logic             ref0_en_s;
        logic             ref1_en_s;
        logic [NODES-1:0] ref0_new_s;
        logic [NODES-1:0] ref1_base_s;
        logic [NODES-1:0] ref1_new_s;

        assign ref0_en_s     = refEn0 & (|refWayVec0) & rdy_q & ~reset;
        assign ref1_en_s     = refEn1 & (|refWayVec1) & rdy_q & ~reset;
        assign ref0_new_s    = plru_touch(tree_q[refIdx0], lowest_way(refWayVec0));
        assign ref1_new_s    = plru_touch(ref1_base_s, lowest_way(refWayVec1));
        assign plru_victim_s = plru_victim(tree_q[lookupIdx]);

        // Same-set dual update: port 1 builds on port 0's result so port 1 ends most recent.
        always_comb begin
            ref1_base_s = tree_q[refIdx1];
            if (ref0_en_s && (refIdx0 == refIdx1)) begin
                ref1_base_s = ref0_new_s;
            end else begin
                ref1_base_s = tree_q[refIdx1];
            end
        end

        // State array: cleared one set per cycle during init, then written by reference ports.
        always_ff @(posedge clk) begin
            if (init_we_s) begin
                tree_q[init_cnt_q] <= '0;
            end else begin
                if (ref0_en_s) begin
                    tree_q[refIdx0] <= ref0_new_s;
                end
                if (ref1_en_s) begin
                    tree_q[refIdx1] <= ref1_new_s;
                end
            end
        end
    end else begin : g_rand
        logic unused_ref_s;
        assign unused_ref_s  = ^{lookupIdx, refIdx0, refWayVec0, refEn0,
                                 refIdx1, refWayVec1, refEn1};
        assign plru_victim_s = '0;
    end

    // Control FSM with registered response outputs and the random-mode LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (MODE == 1) ? ST_READY : ST_INIT;
            init_cnt_q <= '0;
            rdy_q      <= 1'b0;
            rsp_rdy_q  <= 1'b0;
            rsp_q      <= '0;
            vec_q      <= '0;
            lfsr_q     <= 12'h001;
        end else begin
            rsp_rdy_q <= accept_s;
            if (accept_s) begin
                rsp_q <= victim_s;
                vec_q <= N_WAYS'(1'b1) << victim_s;
                if (MODE == 1) begin
                    lfsr_q <= lfsr_d;
                end
            end
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + IDX_W'(1'b1);
                    if (init_cnt_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        rdy_q   <= 1'b1;
                    end
                end
                ST_READY: begin
                    rdy_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rdy          = rdy_q;
    assign lookupRspRdy = rsp_rdy_q;
    assign lookupRsp    = rsp_q;
    assign lookupVecRsp = vec_q;

endmodule

// File: doc/cci_mpf_prim_repl_plru.md
Name: cci_mpf_prim_repl_plru

Overview:
Parametrised victim-selection block for set-associative MPF caches (VTP TLB, WRO tables). It keeps a tree pseudo-LRU state per set and selects a victim way on lookup. Its port list matches the existing random/LRU replacement primitives, so callers can swap policies without changing the surrounding logic. A MODE parameter also selects LFSR-random replacement, for A/B comparison without a rebuild of the caller.

Parameters:
N_WAYS, 4, associativity; power of 2, >= 2
N_ENTRIES, 1024, number of sets; power of 2, >= 2
MODE, 0, 0 = tree PLRU, 1 = LFSR random (state array unused, refs ignored)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rdy  out  1  high once init is complete; stays high until next reset
lookupIdx  in  log2(N_ENTRIES)  set to choose a victim in
lookupEn  in  1  lookup request; accepted only when rdy=1
lookupVecRsp  out  N_WAYS  victim way, one-hot
lookupRsp  out  log2(N_WAYS)  victim way, index
lookupRspRdy  out  1  one-cycle pulse, response valid
refIdx0  in  log2(N_ENTRIES)  port 0 referenced set
refWayVec0  in  N_WAYS  port 0 referenced way(s)
refEn0  in  1  port 0 update valid
refIdx1  in  log2(N_ENTRIES)  port 1 referenced set
refWayVec1  in  N_WAYS  port 1 referenced way(s)
refEn1  in  1  port 1 update valid

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- State: flop array of N_ENTRIES x (N_WAYS-1) tree bits. Heap node numbering: root 0, children of n are 2n+1 (lower ways) and 2n+2 (upper ways).
- Node bit meaning: 0 = victim lies in lower half; 1 = victim lies in upper half.
- FSM states: INIT, READY.
- Reset behaviour: reset enters INIT with init counter = 0. Outputs reset to rdy=0, lookupRspRdy=0, lookupRsp=0, lookupVecRsp=0.
- INIT: clears one set per cycle; counter increments 0..N_ENTRIES-1. After the last set is cleared, the FSM moves to READY and rdy=1 on the following cycle (N_ENTRIES cycles after reset drops).
- In INIT, lookupEn and refEn* are ignored: no response, no update.
- MODE=1 skips INIT: READY and rdy=1 on the first cycle after reset deasserts.
- Reset asserted mid-operation aborts any activity and restarts INIT. Any pending response is dropped.
- Lookup: accepted when lookupEn & rdy. The state of lookupIdx is read in the acceptance cycle. From the root, the block follows each bit (0 -> 2n+1, 1 -> 2n+2) down to a leaf to get the victim.
- lookupRsp, lookupVecRsp and lookupRspRdy are registered: valid exactly 1 cycle after acceptance. lookupRspRdy is a single-cycle pulse; the data outputs hold their value until the next accepted lookup.
- Back-to-back lookups are supported, one per cycle. A lookup does not modify PLRU state.
- Reference update: way w = lowest set bit of refWayVec. An all-zero vector means no update.
- For each node on the path to w, the node bit is set to point away from w: 1 if w is in the lower subtree, 0 otherwise. Off-path nodes are unchanged.
- Updates become visible to lookups accepted on the following cycle or later. A lookup in the same cycle as a ref to the same set sees the pre-update state.
- Both ports may update in the same cycle. Different sets: both updates apply. Same set: port 0 is applied first, then port 1 on top of that result, so port 1's way ends up most recent.
- MODE=1: uses a 12-bit Fibonacci LFSR, taps 12,6,4,1, seeded 12'h001 on reset. It advances once per accepted lookup. Victim = low log2(N_WAYS) bits of the LFSR value before the advance.
- Elaboration fails (assertion) if N_WAYS or N_ENTRIES is not a power of 2, or is < 2.

Test Plan:
- Init (N_ENTRIES=16, N_WAYS=4, MODE=0): release reset -> rdy=0 for exactly 16 cycles, then 1. A lookupEn asserted during init -> no lookupRspRdy.
- After init, lookup idx 5 -> one cycle later lookupRspRdy=1, lookupRsp=0, lookupVecRsp=4'b0001.
- Refs on idx 5 to ways 0, 2, 1, each followed by a lookup -> victims 2, 1, 3 in turn. Idx 6 still returns way 0.
- Same cycle, idx 5 freshly reset: port 0 refs vec 4'b0001, port 1 refs vec 4'b1000 -> next lookup gives way 1. Same cycle, different sets 3 and 4 -> both sets update.
- Ref vec 4'b0110 on a fresh set -> treated as way 1, victim 2. Vec 4'b0000 -> state unchanged. Lookup in the same cycle as a ref to the same set -> returns pre-update victim.
- MODE=1: rdy=1 one cycle after reset. 8 back-to-back lookups -> 8 consecutive lookupRspRdy pulses matching a reference LFSR model. Reset asserted mid-stream -> sequence restarts from seed 12'h001.
